// File: rtl/led_arbiter.sv
// Round-robin owner of the 8-bit LED bank with a minimum hold per grant;
// a heartbeat on led[7:6] is shown whenever no requester is active.
module led_arbiter #(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_data,
  output logic [NREQ-1:0]   grant,
  output logic [2:0]        grant_id,
  output logic              busy,
  output logic [7:0]        led
);

  localparam int              HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]   HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [3:0]      NREQ_W    = 4'(NREQ);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [HW-1:0]     hold_cnt, hold_nxt;
  logic [2:0]        last, last_nxt, id_nxt;
  logic [NREQ-1:0]   grant_nxt;
  logic              busy_nxt;
  logic [7:0]        led_nxt;

  logic [7:0]        req_pad;
  logic [63:0]       data_pad;
  logic [7:0]        cand;
  logic              rr_found;
  logic [2:0]        rr_idx;
  logic [3:0]        idx;
  logic              owner_req;
  logic              release_grant;
  logic [7:0]        led_hb;
  logic [7:0]        owner_data;

  // Padding to 8 lanes lets the 3-bit owner index address requesters for any NREQ.
  always_comb begin
    req_pad    = 8'(req);
    data_pad   = 64'(req_data);
    owner_data = data_pad[{grant_id, 3'b000} +: 8];
    owner_req  = req_pad[grant_id];
    led_hb     = {cnt[CNT_W-1 -: 2], 6'b00_0000};
  end

  // While granted, the current owner is masked out so a handoff never re-picks it.
  always_comb begin
    cand     = (state == GRANT) ? (req_pad & ~8'(grant)) : req_pad;
    rr_found = 1'b0;
    rr_idx   = 3'd0;
    idx      = 4'd0;
    for (int k = 1; k <= 8; k++) begin
      if (k <= NREQ) begin
        idx = {1'b0, last} + 4'(k);
        if (idx >= NREQ_W) begin
          idx = idx - NREQ_W;
        end
        if (!rr_found && cand[idx[2:0]]) begin
          rr_found = 1'b1;
          rr_idx   = idx[2:0];
        end
      end
    end
  end

  assign release_grant = !owner_req || ((hold_cnt == '0) && rr_found);

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    id_nxt    = grant_id;
    busy_nxt  = busy;
    led_nxt   = led;
    hold_nxt  = hold_cnt;
    last_nxt  = last;
    case (state)
      IDLE: begin
        led_nxt   = led_hb;
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        if (rr_found) begin
          state_nxt = GRANT;
          grant_nxt = NREQ'(1) << rr_idx;
          id_nxt    = rr_idx;
          busy_nxt  = 1'b1;
          last_nxt  = rr_idx;
          hold_nxt  = HOLD_LOAD;
        end
      end
      GRANT: begin
        led_nxt  = owner_data;
        hold_nxt = (hold_cnt == '0) ? '0 : hold_cnt - HW'(1);
        if (release_grant) begin
          if (rr_found) begin
            grant_nxt = NREQ'(1) << rr_idx;
            id_nxt    = rr_idx;
            last_nxt  = rr_idx;
            hold_nxt  = HOLD_LOAD;
          end else begin
            state_nxt = IDLE;
            grant_nxt = '0;
            busy_nxt  = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      hold_cnt <= '0;
      last     <= 3'(NREQ - 1);
      grant    <= '0;
      grant_id <= 3'd0;
      busy     <= 1'b0;
      led      <= 8'h00;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt + CNT_W'(1);
      hold_cnt <= hold_nxt;
      last     <= last_nxt;
      grant    <= grant_nxt;
      grant_id <= id_nxt;
      busy     <= busy_nxt;
      led      <= led_nxt;
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(grant));
  a_busy_match:   assert property (@(posedge clk) disable iff (!reset_n) busy == (|grant));

endmodule
